// File: rtl/frame_pkg.sv
// Shared frame-memory constants and playback state encoding, used by the
// capture and playback sides of the frame buffer.
package frame_pkg;

   localparam int unsigned MEM_ADDR_W     = 32'd22;
   localparam int unsigned MEM_DATA_W     = 32'd8;
   localparam int unsigned DEF_LINE_BYTES = 32'd640;
   localparam int unsigned DEF_LINES      = 32'd240;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_OUT    = 2'd2,
      ST_DONE   = 2'd3
   } play_state_t;

   // Counter width that still yields one bit when the range collapses to a single value.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Column/row/address walker over one stored frame; reports the frame and
// line markers for the byte currently addressed.
module frame_pos_counter
   import frame_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 32'd0,
   parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
   parameter int unsigned LINES      = DEF_LINES
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  advance,
   output logic [MEM_ADDR_W-1:0] addr,
   output logic                  sof,
   output logic                  eol,
   output logic                  eof,
   output logic                  last
);

   localparam int unsigned COL_W = cnt_width(LINE_BYTES);
   localparam int unsigned ROW_W = cnt_width(LINES);
   localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(LINE_BYTES - 32'd1);
   localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(LINES - 32'd1);
   localparam logic [MEM_ADDR_W-1:0] ADDR_BASE = MEM_ADDR_W'(BASE_ADDR);

   logic [COL_W-1:0]      col_r;
   logic [ROW_W-1:0]      row_r;
   logic [MEM_ADDR_W-1:0] addr_r;

   // Position registers: restart at the frame origin, step one byte per advance.
   always_ff @(posedge clock) begin
      if (reset) begin
         col_r  <= '0;
         row_r  <= '0;
         addr_r <= '0;
      end else if (clear) begin
         col_r  <= '0;
         row_r  <= '0;
         addr_r <= ADDR_BASE;
      end else if (advance) begin
         addr_r <= addr_r + MEM_ADDR_W'(1);
         if (col_r == COL_LAST) begin
            col_r <= '0;
            row_r <= (row_r == ROW_LAST) ? '0 : row_r + ROW_W'(1);
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   assign addr = addr_r;
   assign sof  = (col_r == '0) && (row_r == '0);
   assign eol  = (col_r == COL_LAST);
   assign eof  = eol && (row_r == ROW_LAST);
   assign last = eof;

endmodule

// File: rtl/frame_playback.sv
// Replays one stored frame from byte-wide memory as a valid/ready byte
// stream carrying start-of-frame, end-of-line and end-of-frame markers.
module frame_playback
   import frame_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 32'd0,
   parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
   parameter int unsigned LINES      = DEF_LINES,
   parameter int unsigned READ_WAIT  = 32'd2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_ce,
   output logic                  mem_oe,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic [MEM_DATA_W-1:0] mem_data,
   output logic [MEM_DATA_W-1:0] pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_sof,
   output logic                  pix_eol,
   output logic                  pix_eof
);

   localparam int unsigned WAIT_W = cnt_width(READ_WAIT + 32'd1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT);

   play_state_t           state_r, state_next;
   logic [WAIT_W-1:0]     wait_r, wait_next;
   logic                  busy_r, busy_next;
   logic                  done_r, done_next;
   logic                  ce_r, ce_next;
   logic                  valid_r, valid_next;
   logic [MEM_DATA_W-1:0] pix_data_r;
   logic                  sof_r, eol_r, eof_r;
   logic                  clear_s, advance_s, capture_s;
   logic                  pos_sof_s, pos_eol_s, pos_eof_s, pos_last_s;

   frame_pos_counter #(
      .BASE_ADDR  (BASE_ADDR),
      .LINE_BYTES (LINE_BYTES),
      .LINES      (LINES)
   ) u_pos (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear_s),
      .advance (advance_s),
      .addr    (mem_addr),
      .sof     (pos_sof_s),
      .eol     (pos_eol_s),
      .eof     (pos_eof_s),
      .last    (pos_last_s)
   );

   // Next-state decode; output next values are computed here and registered below.
   always_comb begin
      state_next = state_r;
      wait_next  = wait_r;
      busy_next  = busy_r;
      ce_next    = ce_r;
      valid_next = valid_r;
      done_next  = 1'b0;
      clear_s    = 1'b0;
      advance_s  = 1'b0;
      capture_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_ACCESS;
               wait_next  = '0;
               busy_next  = 1'b1;
               ce_next    = 1'b1;
               clear_s    = 1'b1;
            end else begin
               busy_next  = 1'b0;
               ce_next    = 1'b0;
               valid_next = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (wait_r == WAIT_LAST) begin
               state_next = ST_OUT;
               ce_next    = 1'b0;
               valid_next = 1'b1;
               capture_s  = 1'b1;
            end else begin
               wait_next = wait_r + WAIT_W'(1);
            end
         end
         ST_OUT: begin
            if (valid_r && pix_ready) begin
               valid_next = 1'b0;
               if (pos_last_s) begin
                  state_next = ST_DONE;
                  done_next  = 1'b1;
               end else begin
                  state_next = ST_ACCESS;
                  wait_next  = '0;
                  ce_next    = 1'b1;
                  advance_s  = 1'b1;
               end
            end else begin
               state_next = ST_OUT;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
         end
         default: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            ce_next    = 1'b0;
            valid_next = 1'b0;
         end
      endcase
   end

   // State register and registered stream/memory outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         wait_r     <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ce_r       <= 1'b0;
         valid_r    <= 1'b0;
         pix_data_r <= '0;
         sof_r      <= 1'b0;
         eol_r      <= 1'b0;
         eof_r      <= 1'b0;
      end else begin
         state_r <= state_next;
         wait_r  <= wait_next;
         busy_r  <= busy_next;
         done_r  <= done_next;
         ce_r    <= ce_next;
         valid_r <= valid_next;
         if (capture_s) begin
            pix_data_r <= mem_data;
            sof_r      <= pos_sof_s;
            eol_r      <= pos_eol_s;
            eof_r      <= pos_eof_s;
         end
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign mem_ce    = ce_r;
   assign mem_oe    = ce_r;
   assign pix_data  = pix_data_r;
   assign pix_valid = valid_r;
   assign pix_sof   = sof_r;
   assign pix_eol   = eol_r;
   assign pix_eof   = eof_r;

endmodule

// File: tb/tb_frame_playback.sv
// Bench for frame_playback: three instances (base 0x100, base 0x3FFFFE, zero wait)
// on a 4x2 frame, each fed by a memory that returns addr[7:0].
module tb_frame_playback;

   localparam int LB    = 4;
   localparam int LN    = 2;
   localparam int NB    = LB * LN;
   localparam int LOG_N = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_v [3];
   logic        ready_v [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic        ce_v    [3];
   logic        oe_v    [3];
   logic [21:0] addr_v  [3];
   logic [7:0]  md_v    [3];
   logic [7:0]  data_v  [3];
   logic        valid_v [3];
   logic        sof_v   [3];
   logic        eol_v   [3];
   logic        eof_v   [3];

   logic [7:0]  pipe1 [2];
   logic [7:0]  pipe2 [2];
   int          edge_cnt = 0;
   logic [32:0] hs_log  [3][LOG_N];
   int          hs_edge [3][LOG_N];
   int          hs_cnt  [3];
   int          done_cnt[3];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          stall;
      logic [7:0]  data;
      logic [21:0] addr;
      logic        sof;
      logic        eol;
      logic        eof;
   } vec_t;
   vec_t tbl [NB];

   always #5 clock = ~clock;

   frame_playback #(.BASE_ADDR(32'h100), .LINE_BYTES(LB), .LINES(LN), .READ_WAIT(2)) u_dut (
      .clock(clock), .reset(reset), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .mem_ce(ce_v[0]), .mem_oe(oe_v[0]), .mem_addr(addr_v[0]), .mem_data(md_v[0]),
      .pix_data(data_v[0]), .pix_valid(valid_v[0]), .pix_ready(ready_v[0]),
      .pix_sof(sof_v[0]), .pix_eol(eol_v[0]), .pix_eof(eof_v[0]));

   frame_playback #(.BASE_ADDR(32'h3FFFFE), .LINE_BYTES(LB), .LINES(LN), .READ_WAIT(2)) u_wrap (
      .clock(clock), .reset(reset), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .mem_ce(ce_v[1]), .mem_oe(oe_v[1]), .mem_addr(addr_v[1]), .mem_data(md_v[1]),
      .pix_data(data_v[1]), .pix_valid(valid_v[1]), .pix_ready(ready_v[1]),
      .pix_sof(sof_v[1]), .pix_eol(eol_v[1]), .pix_eof(eof_v[1]));

   frame_playback #(.BASE_ADDR(32'h100), .LINE_BYTES(LB), .LINES(LN), .READ_WAIT(0)) u_rw0 (
      .clock(clock), .reset(reset), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .mem_ce(ce_v[2]), .mem_oe(oe_v[2]), .mem_addr(addr_v[2]), .mem_data(md_v[2]),
      .pix_data(data_v[2]), .pix_valid(valid_v[2]), .pix_ready(ready_v[2]),
      .pix_sof(sof_v[2]), .pix_eol(eol_v[2]), .pix_eof(eof_v[2]));

   // Memories: two-cycle latency for the READ_WAIT=2 instances, immediate for READ_WAIT=0.
   always @(posedge clock) begin
      for (int g = 0; g < 2; g++) begin
         pipe1[g] <= oe_v[g] ? addr_v[g][7:0] : 8'h00;
         pipe2[g] <= pipe1[g];
      end
   end
   assign md_v[0] = pipe2[0];
   assign md_v[1] = pipe2[1];
   assign md_v[2] = oe_v[2] ? addr_v[2][7:0] : 8'h00;

   // Edge counter plus handshake/done log per instance.
   always @(posedge clock) begin
      edge_cnt <= edge_cnt + 1;
      for (int g = 0; g < 3; g++) begin
         if (!reset && valid_v[g] && ready_v[g]) begin
            if (hs_cnt[g] < LOG_N) begin
               hs_log[g][hs_cnt[g]]  <= {sof_v[g], eol_v[g], eof_v[g], data_v[g], addr_v[g]};
               hs_edge[g][hs_cnt[g]] <= edge_cnt + 1;
            end
            hs_cnt[g] <= hs_cnt[g] + 1;
         end
         if (!reset && done_v[g]) done_cnt[g] <= done_cnt[g] + 1;
      end
   end

   // Reference: byte i of a frame sits at base+i (mod 2^22) and holds the address low byte.
   function automatic logic [32:0] model(input logic [21:0] base, input int i);
      logic [21:0] a;
      a = base + 22'(i);
      return {i == 0, (i % LB) == LB - 1, i == NB - 1, a[7:0], a};
   endfunction

   function automatic logic [37:0] outs(input int g);
      return {busy_v[g], done_v[g], ce_v[g], oe_v[g], addr_v[g], data_v[g],
              valid_v[g], sof_v[g], eol_v[g], eof_v[g]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input int g, input bit rnd, output int k);
      int n;
      int d0;
      d0 = done_cnt[g];
      ready_v[g] = 1'b1;
      start_v[g] = 1'b1;
      k = edge_cnt + 1;
      @(negedge clock);
      n = 0;
      while (!done_v[g] && n < 2000) begin
         if (rnd) begin
            ready_v[g] = 1'($urandom_range(0, 1));
            start_v[g] = 1'($urandom_range(0, 1));
         end else begin
            start_v[g] = 1'b0;
         end
         @(negedge clock);
         n++;
      end
      check("frame_timeout", 64'(n < 2000), 64'd1);
      start_v[g] = rnd;
      @(negedge clock);
      start_v[g] = 1'b0;
      ready_v[g] = 1'b1;
      @(negedge clock);
      check("idle_after_done", {busy_v[g], valid_v[g], ce_v[g]}, 64'd0);
      check("done_pulses", 64'(done_cnt[g] - d0), 64'd1);
   endtask

   task automatic check_frame(input int g, input logic [21:0] base, input int first);
      check("frame_len", 64'(hs_cnt[g] - first), 64'(NB));
      for (int i = 0; i < NB; i++) begin
         if (first + i < LOG_N) check("frame_byte", 64'(hs_log[g][first + i]), 64'(model(base, i)));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ref_e;
      int first;
      int k;
      int d0;

      for (int i = 0; i < NB; i++) begin
         tbl[i] = '{0, 8'(i), 22'h100 + 22'(i), 1'b0, 1'b0, 1'b0};
      end
      tbl[0].sof   = 1'b1;
      tbl[2].stall = 10;
      tbl[3].eol   = 1'b1;
      tbl[7].eol   = 1'b1;
      tbl[7].eof   = 1'b1;

      reset = 1'b1;
      for (int g = 0; g < 3; g++) begin
         start_v[g] = 1'b0;
         ready_v[g] = 1'b0;
      end
      repeat (2) @(negedge clock);
      for (int g = 0; g < 3; g++) check("reset_outputs", 64'(outs(g)), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Table-driven frame on the base-0x100 instance with a stall on byte 2.
      ready_v[0] = 1'b1;
      start_v[0] = 1'b1;
      ref_e = edge_cnt + 1;
      @(negedge clock);
      start_v[0] = 1'b0;
      check("first_access", {busy_v[0], ce_v[0], oe_v[0], valid_v[0], addr_v[0]},
            {1'b1, 1'b1, 1'b1, 1'b0, 22'h100});
      for (int i = 0; i < NB; i++) begin
         n = 0;
         while (!valid_v[0] && n < 50) begin
            @(negedge clock);
            n++;
         end
         check("byte_latency", 64'(edge_cnt - ref_e), 64'd3);
         check("tbl_byte", {sof_v[0], eol_v[0], eof_v[0], data_v[0], addr_v[0]},
               {tbl[i].sof, tbl[i].eol, tbl[i].eof, tbl[i].data, tbl[i].addr});
         if (tbl[i].stall > 0) begin
            ready_v[0] = 1'b0;
            for (int s = 0; s < tbl[i].stall; s++) begin
               @(negedge clock);
               check("stall_hold", {data_v[0], sof_v[0], eol_v[0], eof_v[0], valid_v[0], ce_v[0], oe_v[0]},
                     {tbl[i].data, tbl[i].sof, tbl[i].eol, tbl[i].eof, 1'b1, 1'b0, 1'b0});
            end
            ready_v[0] = 1'b1;
         end
         ref_e = edge_cnt + 1;
         @(negedge clock);
      end
      check("done_after_last", {done_v[0], busy_v[0], valid_v[0]}, {1'b1, 1'b1, 1'b0});
      @(negedge clock);
      check("done_cleared", {done_v[0], busy_v[0]}, 64'd0);

      // Random ready with start hammered while busy and during DONE.
      first = hs_cnt[0];
      run_frame(0, 1'b1, k);
      check_frame(0, 22'h100, first);

      // Reset during the access of byte 5, then a clean replay.
      first = hs_cnt[0];
      ready_v[0] = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clock);
      start_v[0] = 1'b0;
      n = 0;
      while (hs_cnt[0] - first < 5 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("byte5_access", {ce_v[0], valid_v[0], addr_v[0]}, {1'b1, 1'b0, 22'h105});
      d0 = done_cnt[0];
      reset = 1'b1;
      @(negedge clock);
      check("reset_midframe", 64'(outs(0)), 64'd0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check("idle_after_reset", {busy_v[0], valid_v[0], ce_v[0], 32'(done_cnt[0] - d0)}, 64'd0);
      first = hs_cnt[0];
      run_frame(0, 1'b0, k);
      check_frame(0, 22'h100, first);

      // Address wrap at the top of memory.
      first = hs_cnt[1];
      run_frame(1, 1'b1, k);
      check_frame(1, 22'h3FFFFE, first);

      // Zero read wait: one-cycle access, a byte every two cycles.
      first = hs_cnt[2];
      run_frame(2, 1'b0, k);
      check_frame(2, 22'h100, first);
      check("rw0_latency", 64'(hs_edge[2][first] - k), 64'd2);
      for (int i = 1; i < NB; i++) begin
         check("rw0_spacing", 64'(hs_edge[2][first + i] - hs_edge[2][first + i - 1]), 64'd2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_playback.md
# frame_playback

Reads a stored camera frame back out of the external byte-wide frame memory and presents it as a valid/ready byte stream with frame/line markers. It is the read side of the capture path: the capture block writes one frame of 8-bit camera bytes, linearly, from a base address, and this block replays that frame toward the display/UART path. It drives the memory chip-enable, output-enable and 22-bit address, and samples the 8-bit memory data after a fixed access wait.

## Interface
Parameters:
- BASE_ADDR, 0: memory address of the frame's first byte.
- LINE_BYTES, 640: bytes per line (QVGA RGB565 is 320×2).
- LINES, 240: lines per frame.
- READ_WAIT, 2: extra cycles the address is held before data is sampled (≥0).

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin replay of one frame; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse after the last byte handshake.
- mem_ce  out  1  memory chip-enable, active-high.
- mem_oe  out  1  memory output-enable, active-high.
- mem_addr  out  22  memory byte address.
- mem_data  in  8  memory read data.
- pix_data  out  8  stream byte.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  downstream accepts when pix_valid & pix_ready.
- pix_sof  out  1  with pix_valid: first byte of frame.
- pix_eol  out  1  with pix_valid: last byte of a line.
- pix_eof  out  1  with pix_valid: last byte of frame.

## Operation
- States: IDLE, ACCESS, OUT, DONE.
- IDLE: mem_ce=mem_oe=0, pix_valid=0. start=1 → ACCESS. mem_addr<=BASE_ADDR, col<=0, row<=0, wait counter<=0.
- ACCESS: mem_ce=mem_oe=1, mem_addr stable. Lasts exactly READ_WAIT+1 cycles. On its final edge, pix_data<=mem_data, pix_valid<=1, flags registered, → OUT.
- OUT: mem_ce=mem_oe=0. pix_valid, pix_data and flags are held stable until handshake. On handshake:
  - If not last byte: col++ (wrap to 0 and row++ at LINE_BYTES-1), mem_addr++, → ACCESS.
  - If last byte: → DONE.
- DONE: done=1 for one cycle, busy still 1, → IDLE.
- Flags: sof = (row==0 && col==0). eol = (col==LINE_BYTES-1). eof = eol && (row==LINES-1). LINE_BYTES=1 makes every byte eol.
- mem_addr = BASE_ADDR + row*LINE_BYTES + col, kept incrementally. It arithmetically wraps mod 2^22; no error is flagged.
- start while busy: ignored. start in the DONE cycle: ignored.
- Reset at any time, including mid-frame or mid-handshake, returns to IDLE next edge. Every output resets to 0 (mem_addr=0, pix_data=0). No partial done pulse.
- pix_ready is ignored while pix_valid=0.

## Timing
- start sampled at edge k. ACCESS covers cycles k+1..k+READ_WAIT+1. pix_valid is first high in cycle k+READ_WAIT+2.
- With pix_ready held high, each byte costs READ_WAIT+2 cycles. A frame costs LINE_BYTES·LINES·(READ_WAIT+2) cycles plus 1 DONE cycle.
- Last handshake at edge m → done high in cycle m+1, busy low from m+2.
- All outputs are registered. There is no combinational path from pix_ready or mem_data to any output.

## Structure
- Shared package/header frame_pkg: MEM_ADDR_W=22, MEM_DATA_W=8, default LINE_BYTES/LINES (shared with the capture block), and the state encoding localparams.
- One natural sub-module, frame_pos_counter: col/row/addr counters with an advance input, producing the sof/eol/eof/last outputs. It is reusable by the capture side.

## Test plan
(Parameters: LINE_BYTES=4, LINES=2, READ_WAIT=2, BASE_ADDR=0x100. Memory model returns addr[7:0] after 2 cycles.)
- start with pix_ready=1 → 8 bytes 0x00..0x07 at addrs 0x100..0x107, one every 4 cycles. First pix_valid is 4 cycles after the start edge. sof on 0x00, eol on 0x03 and 0x07, eof on 0x07. done occurs 1 cycle after the last handshake.
- Hold pix_ready=0 for 10 cycles on byte 2 → pix_data=0x02 and flags stable. mem_ce=mem_oe=0 during the stall. The stream resumes unchanged.
- Assert start repeatedly while busy → exactly one frame of 8 bytes and a single done pulse.
- Assert reset during the ACCESS of byte 5 → next cycle all outputs are 0 and state is IDLE. A new start replays from 0x100 with sof.
- BASE_ADDR=0x3FFFFE → address sequence 0x3FFFFE, 0x3FFFFF, 0x000000…, and the data matches.
- READ_WAIT=0 → ACCESS is 1 cycle, and bytes arrive every 2 cycles.
